// File: rtl/index_pair_generator_if.sv
// Handshake bundle for the index pair generator: window config in, row index pairs out.
// master is the generator's view; slave is the view of whoever configures and drains it.
interface index_pair_generator_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WORD_WIDTH-1:0] cfg_base;
  logic [WORD_WIDTH-1:0] cfg_rsiz;
  logic [WORD_WIDTH-1:0] cfg_ow;
  logic [WORD_WIDTH-1:0] cfg_kw;
  logic [WORD_WIDTH-1:0] cfg_st;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] idx1;
  logic [WORD_WIDTH-1:0] idx2;
  logic [WORD_WIDTH-1:0] ow;
  logic [WORD_WIDTH-1:0] kw;
  logic [WORD_WIDTH-1:0] st;
  logic                  out_last;
  logic                  done;

  modport master (
    input  cfg_valid, cfg_base, cfg_rsiz, cfg_ow, cfg_kw, cfg_st, out_ready,
    output cfg_ready, out_valid, idx1, idx2, ow, kw, st, out_last, done
  );

  modport slave (
    output cfg_valid, cfg_base, cfg_rsiz, cfg_ow, cfg_kw, cfg_st, out_ready,
    input  cfg_ready, out_valid, idx1, idx2, ow, kw, st, out_last, done
  );
endinterface

// File: rtl/index_pair_generator.sv
// Enumerates every unordered row pair (i<j) of a window; first pair one cycle after config accept.
// One pair per cycle; a stalled pair holds stable until out_ready, done pulses the cycle after the last pair.
module index_pair_generator #(
  parameter int WORD_WIDTH    = 8,
  parameter int MAX_LIFM_RSIZ = 4
) (
  input logic                   clk,
  input logic                   reset,
  index_pair_generator_if.master bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [WORD_WIDTH-1:0] MAX_R = WORD_WIDTH'(MAX_LIFM_RSIZ);
  localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] TWO   = WORD_WIDTH'(2);

  state_t                state_q, state_nxt;
  logic [WORD_WIDTH-1:0] base_q, r_q, i_q, j_q, ow_q, kw_q, st_q;
  logic [WORD_WIDTH-1:0] i_nxt, j_nxt, r_eff;
  logic                  done_q, done_nxt, accept, last;

  assign r_eff = (bus.cfg_rsiz > MAX_R) ? MAX_R : bus.cfg_rsiz;
  assign last  = (state_q == EMIT) && (i_q == r_q - TWO) && (j_q == r_q - ONE);

  always_comb begin
    state_nxt = state_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          accept = 1'b1;
          i_nxt  = '0;
          j_nxt  = ONE;
          // Windows with fewer than two rows have no pairs: finish immediately.
          if (r_eff >= TWO) state_nxt = EMIT;
          else              done_nxt  = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (j_q < r_q - ONE) begin
            j_nxt = j_q + ONE;
          end else begin
            i_nxt = i_q + ONE;
            j_nxt = i_q + TWO;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      base_q  <= '0;
      r_q     <= '0;
      ow_q    <= '0;
      kw_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_nxt;
      i_q     <= i_nxt;
      j_q     <= j_nxt;
      done_q  <= done_nxt;
      if (accept) begin
        base_q <= bus.cfg_base;
        r_q    <= r_eff;
        ow_q   <= bus.cfg_ow;
        kw_q   <= bus.cfg_kw;
        st_q   <= bus.cfg_st;
      end
    end
  end

  // Indices are derived from the held counters, so they cannot move during a stall.
  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.idx1      = base_q + i_q;
  assign bus.idx2      = base_q + j_q;
  assign bus.out_last  = last;
  assign bus.done      = done_q;
  assign bus.ow        = ow_q;
  assign bus.kw        = kw_q;
  assign bus.st        = st_q;

endmodule

// File: tb/tb_index_pair_generator.sv
// Scoreboard bench for index_pair_generator: expected pairs are queued per window and popped on each handshake.
module tb_index_pair_generator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  index_pair_generator_if #(.WORD_WIDTH(W)) bus ();
  index_pair_generator #(.WORD_WIDTH(W), .MAX_LIFM_RSIZ(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic         last;
  } pair_t;

  pair_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void push_window(input int base, input int rsiz);
    int r;
    pair_t p;
    r = (rsiz > 4) ? 4 : rsiz;
    for (int i = 0; i < r; i++) begin
      for (int j = i + 1; j < r; j++) begin
        p.i1   = W'(base + i);
        p.i2   = W'(base + j);
        p.last = (i == r - 2) && (j == r - 1);
        sb_q.push_back(p);
      end
    end
  endfunction

  task automatic send_cfg(input int base, input int rsiz, input int ow, input int kw, input int st);
    @(negedge clk);
    bus.cfg_base  = W'(base);
    bus.cfg_rsiz  = W'(rsiz);
    bus.cfg_ow    = W'(ow);
    bus.cfg_kw    = W'(kw);
    bus.cfg_st    = W'(st);
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.cfg_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.cfg_base  = '0;
    bus.cfg_rsiz  = '0;
    bus.cfg_ow    = '0;
    bus.cfg_kw    = '0;
    bus.cfg_st    = '0;
    #1 reset = 1'b1;
    #2;
    n_cmp++; if ({bus.out_valid, bus.out_last, bus.done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {bus.out_valid, bus.out_last, bus.done}); end
    n_cmp++; if ({bus.idx1, bus.idx2} !== '0) begin n_bad++; $display("FAIL reset_idx got %0d,%0d want 0,0", bus.idx1, bus.idx2); end
    n_cmp++; if ({bus.ow, bus.kw, bus.st} !== '0) begin n_bad++; $display("FAIL reset_geom got %0d/%0d/%0d want 0/0/0", bus.ow, bus.kw, bus.st); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
  endtask

  task automatic test_basic;
    pair_t e;
    bus.out_ready = 1'b1;
    push_window(10, 4);
    send_cfg(10, 4, 6, 3, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid[%0d] got %b want 1", k, bus.out_valid); end
      if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL basic_sb_empty at pair %0d", k); end
      else begin
        e = sb_q.pop_front();
        n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL basic_pair[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", k, bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
      end
      if (k == 0) begin
        n_cmp++; if ({bus.ow, bus.kw, bus.st} !== {8'd6, 8'd3, 8'd1}) begin n_bad++; $display("FAIL basic_geom got %0d/%0d/%0d want 6/3/1", bus.ow, bus.kw, bus.st); end
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL basic_cfg_ready_emit got %b want 0", bus.cfg_ready); end
      end
    end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.out_valid, bus.cfg_ready} !== 3'b101) begin n_bad++; $display("FAIL basic_done got done/valid/ready=%b want 101", {bus.done, bus.out_valid, bus.cfg_ready}); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_backpressure;
    pair_t e;
    int vc = 0;
    int hs = 0;
    bit seen_done = 1'b0;
    bus.out_ready = 1'b0;
    push_window(40, 3);
    send_cfg(40, 3, 4, 2, 2);
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
      if (bus.out_valid === 1'b1) begin
        bus.out_ready = (vc >= 3);
        vc++;
        if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL bp_extra_pair got (%0d,%0d)", bus.idx1, bus.idx2); end
        else begin
          e = sb_q[0];
          n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL bp_pair cyc%0d got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", vc, bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
          if (bus.out_ready) begin void'(sb_q.pop_front()); hs++; end
        end
      end
    end
    n_cmp++; if (!seen_done) begin n_bad++; $display("FAIL bp_timeout done not seen within budget"); end
    n_cmp++; if (hs != 3) begin n_bad++; $display("FAIL bp_handshakes got %0d want 3", hs); end
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL bp_leftover got %0d pairs want 0", sb_q.size()); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_clamp_wrap;
    pair_t e;
    bus.out_ready = 1'b1;
    push_window(254, 9);
    send_cfg(254, 9, 5, 5, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid[%0d] got %b want 1", k, bus.out_valid); end
      if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL wrap_sb_empty at pair %0d", k); end
      else begin
        e = sb_q.pop_front();
        n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL wrap_pair[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", k, bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
      end
    end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL wrap_done got done/valid=%b want 10", {bus.done, bus.out_valid}); end
  endtask

  task automatic test_degenerate;
    for (int r = 0; r < 2; r++) begin
      send_cfg(77, r, 1, 1, 1);
      @(negedge clk);
      n_cmp++; if ({bus.done, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL degen_r%0d_done got done/valid=%b want 10", r, {bus.done, bus.out_valid}); end
      @(negedge clk);
      n_cmp++; if ({bus.done, bus.out_valid, bus.cfg_ready} !== 3'b001) begin n_bad++; $display("FAIL degen_r%0d_after got done/valid/ready=%b want 001", r, {bus.done, bus.out_valid, bus.cfg_ready}); end
    end
  endtask

  task automatic test_reset_mid;
    pair_t e;
    bus.out_ready = 1'b1;
    send_cfg(20, 4, 6, 3, 1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({bus.out_valid, bus.out_last, bus.done} !== 3'b000) begin n_bad++; $display("FAIL rmid_flags got %b want 000", {bus.out_valid, bus.out_last, bus.done}); end
    n_cmp++; if ({bus.idx1, bus.idx2} !== '0) begin n_bad++; $display("FAIL rmid_idx got %0d,%0d want 0,0", bus.idx1, bus.idx2); end
    n_cmp++; if ({bus.ow, bus.kw, bus.st} !== '0) begin n_bad++; $display("FAIL rmid_geom got %0d/%0d/%0d want 0/0/0", bus.ow, bus.kw, bus.st); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done[%0d] got %b want 0", k, bus.done); end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.cfg_base  = 8'd0;
    bus.cfg_rsiz  = 8'd2;
    bus.cfg_valid = 1'b1;
    push_window(0, 2);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_new_valid got %b want 1", bus.out_valid); end
    if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rmid_sb_empty"); end
    else begin
      e = sb_q.pop_front();
      n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL rmid_pair got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
    end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL rmid_done got done/valid=%b want 10", {bus.done, bus.out_valid}); end
  endtask

  task automatic test_back_to_back;
    pair_t e;
    bus.out_ready = 1'b1;
    push_window(100, 2);
    push_window(50, 3);
    @(negedge clk);
    bus.cfg_base = 8'd100; bus.cfg_rsiz = 8'd2; bus.cfg_ow = 8'd7; bus.cfg_kw = 8'd2; bus.cfg_st = 8'd2;
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_base = 8'd50; bus.cfg_rsiz = 8'd3; bus.cfg_ow = 8'd9; bus.cfg_kw = 8'd5; bus.cfg_st = 8'd3;
    @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.cfg_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b_emit got valid/ready=%b want 10", {bus.out_valid, bus.cfg_ready}); end
    n_cmp++; if ({bus.ow, bus.kw, bus.st} !== {8'd7, 8'd2, 8'd2}) begin n_bad++; $display("FAIL b2b_geom_a got %0d/%0d/%0d want 7/2/2", bus.ow, bus.kw, bus.st); end
    e = sb_q.pop_front();
    n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL b2b_pair_a got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.cfg_ready, bus.out_valid} !== 3'b110) begin n_bad++; $display("FAIL b2b_gap got done/ready/valid=%b want 110", {bus.done, bus.cfg_ready, bus.out_valid}); end
    n_cmp++; if (bus.ow !== 8'd7) begin n_bad++; $display("FAIL b2b_geom_hold got ow=%0d want 7", bus.ow); end
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if ({bus.ow, bus.kw, bus.st} !== {8'd9, 8'd5, 8'd3}) begin n_bad++; $display("FAIL b2b_geom_b got %0d/%0d/%0d want 9/5/3", bus.ow, bus.kw, bus.st); end
      end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_b[%0d] got %b want 1", k, bus.out_valid); end
      if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL b2b_sb_empty at pair %0d", k); end
      else begin
        e = sb_q.pop_front();
        n_cmp++; if ({bus.idx1, bus.idx2, bus.out_last} !== {e.i1, e.i2, e.last}) begin n_bad++; $display("FAIL b2b_pair_b[%0d] got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", k, bus.idx1, bus.idx2, bus.out_last, e.i1, e.i2, e.last); end
      end
    end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_done_b got done/valid=%b want 10", {bus.done, bus.out_valid}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp_wrap();
    test_degenerate();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
